// File: rtl/cast_output_port_arbiter_pkg.sv
// Shared router constants (ports, VCs, flit width) and the small index helpers
// used by the output-port switch allocator and, later, the VC allocator.
package cast_output_port_arbiter_pkg;

  localparam int PN     = 5;
  localparam int VN     = 2;
  localparam int DW     = 16;
  localparam int NR_DEF = PN * VN;

  // Requester r = port*VN + vc, so the VC index is simply r mod VN.
  function automatic int vc_of(input int r);
    return r % VN;
  endfunction

  function automatic logic [VN-1:0] vc_onehot(input int r);
    logic [VN-1:0] one;
    one = {{(VN-1){1'b0}}, 1'b1};
    return one << vc_of(r);
  endfunction

  function automatic int port_of(input int r);
    return r / VN;
  endfunction

endpackage

// File: rtl/cast_output_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches circularly from last_i+1 and
// returns the one-hot winner plus its encoded index.
module rr_arbiter #(
  parameter  int NR = 4,
  localparam int IW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic [NR-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic [NR-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // cand wraps explicitly at NR-1 so non-power-of-two NR never indexes past the vector.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = last_i;
    for (int k = 0; k < NR; k++) begin
      cand = (cand == IW'(NR - 1)) ? '0 : cand + 1'b1;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/cast_output_port_arbiter.sv
// Output-port switch allocator: round-robin grant among all port/VC requesters
// feeding a single-entry valid/ready output register toward the link.
module cast_output_port_arbiter
  import cast_output_port_arbiter_pkg::*;
#(
  parameter int NR      = NR_DEF,
  parameter int PORT_ID = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [NR-1:0] req_i,
  input  logic [DW-1:0] data_i [NR],
  output logic [NR-1:0] gnt_o,
  output logic [NR-1:0] sel_o,
  output logic [DW-1:0] data_o,
  output logic [VN-1:0] vc_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam int IW = (NR > 1) ? $clog2(NR) : 1;

  // Handshake: a flit moves downstream when valid_o & ready_i; while
  // valid_o & ~ready_i the register and pointer hold and no grant is issued.
  logic [IW-1:0] last_q, last_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [VN-1:0] vc_q, vc_d;

  logic          load;
  logic          grant;
  logic [NR-1:0] win_oh;
  logic [IW-1:0] win_idx;
  logic          win_any;

  rr_arbiter #(.NR(NR)) u_rr (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (win_oh),
    .idx_o  (win_idx),
    .any_o  (win_any)
  );

  // rstn gates the grant so requesters see no consumption while reset is held.
  always_comb begin
    load    = ~valid_q | ready_i;
    grant   = win_any & load & rstn;
    gnt_o   = grant ? win_oh : '0;
    sel_o   = gnt_o;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    vc_d    = vc_q;
    if (load) begin
      valid_d = grant;
    end
    if (grant) begin
      data_d = data_i[win_idx];
      vc_d   = vc_onehot(int'(win_idx));
      last_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q  <= IW'(NR - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
      vc_q    <= '0;
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      vc_q    <= vc_d;
    end
  end

  assign data_o  = data_q;
  assign vc_o    = vc_q;
  assign valid_o = valid_q;

  a_port_id: assert property (@(posedge clk) (PORT_ID >= 0) && (PORT_ID < PN));

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt_o));

  a_no_gnt_when_full: assert property (@(posedge clk) disable iff (!rstn)
    (valid_o && !ready_i) |-> (gnt_o == '0));

  a_hold_when_stalled: assert property (@(posedge clk) disable iff (!rstn)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(vc_o)));

endmodule

// File: tb/tb_cast_output_port_arbiter.sv
// Directed bench for the output-port arbiter with PN=5, VN=2 (NR=10).
module tb_cast_output_port_arbiter;
  import cast_output_port_arbiter_pkg::*;

  localparam int NR = NR_DEF;

  logic          clk;
  logic          rstn;
  logic [NR-1:0] req_i;
  logic [DW-1:0] data_i [NR];
  logic [NR-1:0] gnt_o;
  logic [NR-1:0] sel_o;
  logic [DW-1:0] data_o;
  logic [VN-1:0] vc_o;
  logic          valid_o;
  logic          ready_i;

  int checks   = 0;
  int failures = 0;

  cast_output_port_arbiter #(.NR(NR), .PORT_ID(0)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_i   (req_i),
    .data_i  (data_i),
    .gnt_o   (gnt_o),
    .sel_o   (sel_o),
    .data_o  (data_o),
    .vc_o    (vc_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rstn    = 1'b0;
    req_i   = '0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // advance to just after the next active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn    = 1'b0;
    req_i   = '1;
    ready_i = 1'b1;
    #3;
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++;
    if (data_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
    checks++;
    if (vc_o !== 2'b00) begin failures++; $display("FAIL reset_vc got=%b exp=00", vc_o); end
    checks++;
    if (gnt_o !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt_o); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    data_i[3] = 16'h00A5;
    req_i     = 10'b00_0000_1000;
    ready_i   = 1'b1;
    #2;
    checks++;
    if (gnt_o !== 10'b00_0000_1000) begin failures++; $display("FAIL single_gnt got=%b exp=0000001000", gnt_o); end
    checks++;
    if (sel_o !== 10'b00_0000_1000) begin failures++; $display("FAIL single_sel got=%b exp=0000001000", sel_o); end
    step();
    req_i = '0;
    checks++;
    if (valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid_o); end
    checks++;
    if (data_o !== 16'h00A5) begin failures++; $display("FAIL single_data got=%h exp=00a5", data_o); end
    checks++;
    if (vc_o !== 2'b10) begin failures++; $display("FAIL single_vc got=%b exp=10", vc_o); end
  endtask

  task automatic test_all_requesting();
    logic [NR-1:0] exp_g;
    logic [VN-1:0] exp_vc;
    do_reset();
    for (int i = 0; i < NR; i++) data_i[i] = 16'h0010 + 16'(i);
    req_i   = '1;
    ready_i = 1'b1;
    for (int n = 0; n < NR + 1; n++) begin
      exp_g  = 10'b1 << (n % NR);
      exp_vc = (n % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      checks++;
      if (gnt_o !== exp_g) begin failures++; $display("FAIL all_gnt n=%0d got=%b exp=%b", n, gnt_o, exp_g); end
      step();
      checks++;
      if (valid_o !== 1'b1) begin failures++; $display("FAIL all_valid n=%0d got=%b exp=1", n, valid_o); end
      checks++;
      if (data_o !== 16'h0010 + 16'(n % NR)) begin
        failures++; $display("FAIL all_data n=%0d got=%h exp=%h", n, data_o, 16'h0010 + 16'(n % NR));
      end
      checks++;
      if (vc_o !== exp_vc) begin failures++; $display("FAIL all_vc n=%0d got=%b exp=%b", n, vc_o, exp_vc); end
    end
    req_i = '0;
  endtask

  task automatic test_two_requesters();
    logic [NR-1:0] exp_g [3];
    exp_g[0] = 10'b00_0000_0100;
    exp_g[1] = 10'b00_1000_0000;
    exp_g[2] = 10'b00_0000_0100;
    do_reset();
    data_i[2] = 16'h0022;
    data_i[7] = 16'h0077;
    req_i     = 10'b00_1000_0000;
    ready_i   = 1'b1;
    #2;
    checks++;
    if (gnt_o !== 10'b00_1000_0000) begin failures++; $display("FAIL two_setup_gnt got=%b exp=0010000000", gnt_o); end
    step();
    req_i = 10'b00_1000_0100;
    for (int n = 0; n < 3; n++) begin
      #2;
      checks++;
      if (gnt_o !== exp_g[n]) begin failures++; $display("FAIL two_gnt n=%0d got=%b exp=%b", n, gnt_o, exp_g[n]); end
      step();
      checks++;
      if (data_o !== ((n == 1) ? 16'h0077 : 16'h0022)) begin
        failures++; $display("FAIL two_data n=%0d got=%h exp=%h", n, data_o, (n == 1) ? 16'h0077 : 16'h0022);
      end
    end
    req_i = '0;
  endtask

  task automatic test_backpressure_and_idle();
    do_reset();
    data_i[5] = 16'h0055;
    data_i[6] = 16'h0066;
    data_i[7] = 16'h0077;
    data_i[0] = 16'h0F00;
    req_i     = 10'b00_0010_0000;
    ready_i   = 1'b1;
    step();
    req_i   = 10'b00_0100_0000;
    ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #2;
      checks++;
      if (gnt_o !== '0) begin failures++; $display("FAIL bp_gnt n=%0d got=%b exp=0", n, gnt_o); end
      step();
      checks++;
      if (valid_o !== 1'b1 || data_o !== 16'h0055 || vc_o !== 2'b10) begin
        failures++; $display("FAIL bp_hold n=%0d got=%b/%h/%b exp=1/0055/10", n, valid_o, data_o, vc_o);
      end
    end
    ready_i = 1'b1;
    #2;
    checks++;
    if (gnt_o !== 10'b00_0100_0000) begin failures++; $display("FAIL bp_resume_gnt got=%b exp=0001000000", gnt_o); end
    step();
    checks++;
    if (data_o !== 16'h0066 || vc_o !== 2'b01) begin
      failures++; $display("FAIL bp_resume_out got=%h/%b exp=0066/01", data_o, vc_o);
    end
    // idle with ready: register empties, pointer stays on 6
    req_i = '0;
    #2;
    checks++;
    if (gnt_o !== '0) begin failures++; $display("FAIL idle_gnt got=%b exp=0", gnt_o); end
    step();
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", valid_o); end
    req_i = 10'b00_1000_0001;
    #2;
    checks++;
    if (gnt_o !== 10'b00_1000_0000) begin failures++; $display("FAIL idle_ptr_gnt got=%b exp=0010000000", gnt_o); end
    step();
    req_i = '0;
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'h0077) begin
      failures++; $display("FAIL idle_ptr_out got=%b/%h exp=1/0077", valid_o, data_o);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    for (int i = 0; i < NR; i++) data_i[i] = 16'h0100 + 16'(i);
    req_i   = '1;
    ready_i = 1'b1;
    repeat (4) step();
    checks++;
    if (valid_o !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", valid_o); end
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", valid_o); end
    checks++;
    if (gnt_o !== '0) begin failures++; $display("FAIL mid_gnt got=%b exp=0", gnt_o); end
    checks++;
    if (data_o !== '0) begin failures++; $display("FAIL mid_data got=%h exp=0", data_o); end
    @(negedge clk);
    rstn = 1'b1;
    #2;
    checks++;
    if (gnt_o !== 10'b00_0000_0001) begin failures++; $display("FAIL mid_after_gnt got=%b exp=0000000001", gnt_o); end
    step();
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'h0100 || vc_o !== 2'b01) begin
      failures++; $display("FAIL mid_after_out got=%b/%h/%b exp=1/0100/01", valid_o, data_o, vc_o);
    end
    req_i = '0;
  endtask

  initial begin
    rstn    = 1'b0;
    req_i   = '0;
    ready_i = 1'b0;
    for (int i = 0; i < NR; i++) data_i[i] = '0;
    test_reset();
    test_single();
    test_all_requesting();
    test_two_requesters();
    test_backpressure_and_idle();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
